// File: rtl/pacman_draw_ctrl.sv
// Pixel sequencer feeding the VGA source mux: full-screen background wipe, or
// sprite erase-at-old / draw-at-new, one registered pixel per clock.
module pacman_draw_ctrl #(
    parameter int   SCREEN_W    = 160,
    parameter int   SCREEN_H    = 120,
    parameter int   SPRITE_SIZE = 4,
    parameter logic BG_COLOUR   = 1'b0,
    parameter logic PAC_COLOUR  = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       init_bg,
    input  logic       move_req,
    input  logic [7:0] new_x,
    input  logic [6:0] new_y,
    output logic       busy,
    output logic       done,
    output logic [2:0] mux_select,
    output logic [7:0] x_bg,
    output logic [6:0] y_bg,
    output logic       colour_bg,
    output logic [7:0] x_pacman,
    output logic [6:0] y_pacman,
    output logic       colour_pacman,
    output logic       plot
);

    localparam int CW = (SPRITE_SIZE > 1) ? $clog2(SPRITE_SIZE) : 1;

    typedef enum logic [2:0] {S_IDLE, S_BG_FILL, S_ERASE, S_DRAW, S_DONE} state_t;

    state_t        state_q;
    logic [7:0]    old_x_q, tgt_x_q, cx_q;
    logic [6:0]    old_y_q, tgt_y_q, cy_q;
    logic          have_old_q;
    logic [CW-1:0] dx_q, dy_q;

    logic       busy_q, done_q, plot_q, colour_bg_q, colour_pacman_q;
    logic [2:0] mux_select_q;
    logic [7:0] x_bg_q, x_pacman_q;
    logic [6:0] y_bg_q, y_pacman_q;

    // Sums are one bit wider so off-screen pixels can be detected and suppressed.
    logic [8:0] old_sx, tgt_sx;
    logic [7:0] old_sy, tgt_sy;
    logic       old_on, tgt_on, dx_last, dy_last;

    assign old_sx  = {1'b0, old_x_q} + 9'(dx_q);
    assign old_sy  = {1'b0, old_y_q} + 8'(dy_q);
    assign tgt_sx  = {1'b0, tgt_x_q} + 9'(dx_q);
    assign tgt_sy  = {1'b0, tgt_y_q} + 8'(dy_q);
    assign old_on  = (old_sx < 9'(SCREEN_W)) && (old_sy < 8'(SCREEN_H));
    assign tgt_on  = (tgt_sx < 9'(SCREEN_W)) && (tgt_sy < 8'(SCREEN_H));
    assign dx_last = (dx_q == CW'(SPRITE_SIZE - 1));
    assign dy_last = (dy_q == CW'(SPRITE_SIZE - 1));

    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            old_x_q         <= '0;
            old_y_q         <= '0;
            tgt_x_q         <= '0;
            tgt_y_q         <= '0;
            have_old_q      <= 1'b0;
            cx_q            <= '0;
            cy_q            <= '0;
            dx_q            <= '0;
            dy_q            <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            plot_q          <= 1'b0;
            mux_select_q    <= 3'b000;
            x_bg_q          <= '0;
            y_bg_q          <= '0;
            colour_bg_q     <= 1'b0;
            x_pacman_q      <= '0;
            y_pacman_q      <= '0;
            colour_pacman_q <= 1'b0;
        end else begin
            done_q          <= 1'b0;
            plot_q          <= 1'b0;
            mux_select_q    <= 3'b000;
            x_bg_q          <= '0;
            y_bg_q          <= '0;
            colour_bg_q     <= 1'b0;
            x_pacman_q      <= '0;
            y_pacman_q      <= '0;
            colour_pacman_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    // busy_q still high here means the done cycle just ended.
                    if (busy_q) begin
                        busy_q <= 1'b0;
                    end else if (init_bg) begin
                        state_q    <= S_BG_FILL;
                        busy_q     <= 1'b1;
                        have_old_q <= 1'b0;
                        cx_q       <= '0;
                        cy_q       <= '0;
                    end else if (move_req) begin
                        state_q <= have_old_q ? S_ERASE : S_DRAW;
                        busy_q  <= 1'b1;
                        tgt_x_q <= new_x;
                        tgt_y_q <= new_y;
                        dx_q    <= '0;
                        dy_q    <= '0;
                    end
                end
                S_BG_FILL: begin
                    x_bg_q      <= cx_q;
                    y_bg_q      <= cy_q;
                    colour_bg_q <= BG_COLOUR;
                    plot_q      <= 1'b1;
                    if (cx_q == 8'(SCREEN_W - 1)) begin
                        cx_q <= '0;
                        if (cy_q == 7'(SCREEN_H - 1)) begin
                            cy_q    <= '0;
                            state_q <= S_DONE;
                        end else begin
                            cy_q <= cy_q + 7'd1;
                        end
                    end else begin
                        cx_q <= cx_q + 8'd1;
                    end
                end
                S_ERASE: begin
                    x_bg_q      <= old_sx[7:0];
                    y_bg_q      <= old_sy[6:0];
                    colour_bg_q <= BG_COLOUR;
                    plot_q      <= old_on;
                    if (dx_last && dy_last) state_q <= S_DRAW;
                end
                S_DRAW: begin
                    mux_select_q    <= 3'b001;
                    x_pacman_q      <= tgt_sx[7:0];
                    y_pacman_q      <= tgt_sy[6:0];
                    colour_pacman_q <= PAC_COLOUR;
                    plot_q          <= tgt_on;
                    if (dx_last && dy_last) begin
                        state_q    <= S_DONE;
                        old_x_q    <= tgt_x_q;
                        old_y_q    <= tgt_y_q;
                        have_old_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            if (state_q == S_ERASE || state_q == S_DRAW) begin
                if (dx_last) begin
                    dx_q <= '0;
                    dy_q <= dy_last ? '0 : dy_q + CW'(1);
                end else begin
                    dx_q <= dx_q + CW'(1);
                end
            end
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign plot          = plot_q;
    assign mux_select    = mux_select_q;
    assign x_bg          = x_bg_q;
    assign y_bg          = y_bg_q;
    assign colour_bg     = colour_bg_q;
    assign x_pacman      = x_pacman_q;
    assign y_pacman      = y_pacman_q;
    assign colour_pacman = colour_pacman_q;

endmodule

// File: tb/tb_pacman_draw_ctrl.sv
// Self-checking bench for pacman_draw_ctrl: expected pixel streams are built
// from screen/sprite geometry and compared plot-by-plot against the DUT.
module tb_pacman_draw_ctrl;

    localparam int W = 160;
    localparam int H = 120;
    localparam int S = 4;

    typedef logic [34:0] pix_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       init_bg = 1'b0;
    logic       move_req = 1'b0;
    logic [7:0] new_x = '0;
    logic [6:0] new_y = '0;
    logic       busy, done, colour_bg, colour_pacman, plot;
    logic [2:0] mux_select;
    logic [7:0] x_bg, x_pacman;
    logic [6:0] y_bg, y_pacman;

    int checks = 0;
    int failures = 0;

    bit m_have_old = 1'b0;
    int m_old_x = 0;
    int m_old_y = 0;

    pacman_draw_ctrl dut (
        .clock(clock), .reset(reset), .init_bg(init_bg), .move_req(move_req),
        .new_x(new_x), .new_y(new_y), .busy(busy), .done(done),
        .mux_select(mux_select), .x_bg(x_bg), .y_bg(y_bg), .colour_bg(colour_bg),
        .x_pacman(x_pacman), .y_pacman(y_pacman), .colour_pacman(colour_pacman),
        .plot(plot)
    );

    always #5 clock = ~clock;

    function automatic pix_t observed();
        return {mux_select, x_bg, y_bg, colour_bg, x_pacman, y_pacman, colour_pacman};
    endfunction

    // Appends the on-screen pixels of one sprite, row-major.
    task automatic push_sprite(inout pix_t q[$], input bit is_draw, input int bx, input int by);
        for (int dy = 0; dy < S; dy++)
            for (int dx = 0; dx < S; dx++)
                if (bx + dx < W && by + dy < H) begin
                    if (is_draw)
                        q.push_back({3'b001, 8'd0, 7'd0, 1'b0, 8'(bx + dx), 7'(by + dy), 1'b1});
                    else
                        q.push_back({3'b000, 8'(bx + dx), 7'(by + dy), 1'b0, 8'd0, 7'd0, 1'b0});
                end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        m_have_old = 1'b0;
    endtask

    // Issues one request, checks every plotted pixel, done timing and idle return.
    task automatic run_req(input string name, input bit do_bg, input bit do_move,
                           input logic [7:0] nx, input logic [6:0] ny, input int poke_k);
        pix_t exp_q[$];
        int   n_cycles;
        bit   got_done = 1'b0;
        if (do_bg) begin
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    exp_q.push_back({3'b000, 8'(x), 7'(y), 1'b0, 8'd0, 7'd0, 1'b0});
            n_cycles   = W * H;
            m_have_old = 1'b0;
        end else begin
            n_cycles = S * S;
            if (m_have_old) begin
                push_sprite(exp_q, 1'b0, m_old_x, m_old_y);
                n_cycles = 2 * S * S;
            end
            push_sprite(exp_q, 1'b1, int'(nx), int'(ny));
            m_have_old = 1'b1;
            m_old_x    = int'(nx);
            m_old_y    = int'(ny);
        end

        @(negedge clock);
        init_bg  = do_bg;
        move_req = do_move;
        new_x    = nx;
        new_y    = ny;
        @(negedge clock);
        init_bg  = 1'b0;
        move_req = 1'b0;
        checks++;
        if (busy !== 1'b1 || plot !== 1'b0) begin
            failures++;
            $display("FAIL %s accept: busy=%b plot=%b required busy=1 plot=0", name, busy, plot);
        end

        for (int k = 1; k <= n_cycles + 4 && !got_done; k++) begin
            @(negedge clock);
            if (plot === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s extra_plot k=%0d: got %h required no plot", name, k, observed());
                end else begin
                    if (observed() !== exp_q[0]) begin
                        failures++;
                        $display("FAIL %s pixel k=%0d: got %h required %h", name, k, observed(), exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (done === 1'b1) begin
                got_done = 1'b1;
                checks++;
                if (k != n_cycles + 1 || plot !== 1'b0 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s done_timing: done at k=%0d plot=%b busy=%b required k=%0d plot=0 busy=1",
                             name, k, plot, busy, n_cycles + 1);
                end
            end
            // Requests raised while busy must be ignored.
            move_req = (k == poke_k) || (got_done && poke_k > 0);
            new_x    = 8'($urandom);
            new_y    = 7'($urandom);
        end

        checks++;
        if (!got_done || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s completion: done_seen=%b missing_plots=%0d required done_seen=1 missing_plots=0",
                     name, got_done, exp_q.size());
        end
        @(negedge clock);
        move_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || plot !== 1'b0 || observed() !== '0) begin
                failures++;
                $display("FAIL %s idle_after %0d: busy=%b done=%b plot=%b bus=%h required all 0",
                         name, i, busy, done, plot, observed());
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || plot !== 1'b0 || observed() !== '0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b plot=%b bus=%h required all 0",
                     busy, done, plot, observed());
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_first_draw();
        run_req("first_draw", 1'b0, 1'b1, 8'd10, 7'd20, 0);
    endtask

    task automatic test_erase_draw();
        run_req("erase_draw", 1'b0, 1'b1, 8'd11, 7'd20, 7);
    endtask

    task automatic test_bg_fill();
        run_req("bg_fill", 1'b1, 1'b0, 8'd0, 7'd0, 0);
        run_req("move_after_fill", 1'b0, 1'b1, 8'd30, 7'd40, 3);
    endtask

    task automatic test_clip_corner();
        do_reset();
        run_req("clip_corner", 1'b0, 1'b1, 8'd158, 7'd118, 0);
    endtask

    task automatic test_reset_mid_draw();
        run_req("pre_reset_move", 1'b0, 1'b1, 8'd50, 7'd50, 0);
        @(negedge clock);
        move_req = 1'b1;
        new_x    = 8'd60;
        new_y    = 7'd60;
        @(negedge clock);
        move_req = 1'b0;
        // Skip past the 16 erase cycles into the draw phase.
        repeat (20) @(negedge clock);
        checks++;
        if (plot !== 1'b1 || mux_select !== 3'b001) begin
            failures++;
            $display("FAIL mid_draw_active: plot=%b mux=%b required plot=1 mux=001", plot, mux_select);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || observed() !== '0) begin
            failures++;
            $display("FAIL mid_draw_reset: plot=%b busy=%b done=%b bus=%h required all 0",
                     plot, busy, done, observed());
        end
        @(negedge clock);
        reset      = 1'b0;
        m_have_old = 1'b0;
        run_req("draw_after_reset", 1'b0, 1'b1, 8'd70, 7'd80, 0);
    endtask

    task automatic test_simultaneous();
        run_req("bg_priority", 1'b1, 1'b1, 8'd5, 7'd5, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++)
            run_req("random_move", 1'b0, 1'b1, 8'($urandom_range(0, 170)),
                    7'($urandom_range(0, 127)), int'($urandom_range(0, 34)));
    endtask

    initial begin
        test_reset();
        test_first_draw();
        test_erase_draw();
        test_bg_fill();
        test_clip_corner();
        test_reset_mid_draw();
        test_simultaneous();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
